// File: rtl/unidade_controle_rodadas.sv
// Round sequencer for the sequence-memory game.
// Round k asks the player to repeat stored plays 0..k in order, and every
// wait for a play is guarded by a cycle-count timeout.
// All outputs are registered: they are decoded from the next state and
// loaded together with it, so they always agree with the current state.

module unidade_controle_rodadas #(
   parameter int N_JOGADAS      = 16,
   parameter int TIMEOUT_CICLOS = 3000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       tem_jogada,
   input  logic       igual,
   output logic [3:0] endereco,
   output logic [3:0] rodada,
   output logic       zera_reg,
   output logic       registra,
   output logic       acertou,
   output logic       errou,
   output logic       timeout,
   output logic       pronto,
   output logic [3:0] db_estado
);

   // Counter width is ceil(log2(TIMEOUT_CICLOS)), but never less than one bit.
   localparam int CW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
   localparam logic [CW-1:0] LIMITE = CW'(TIMEOUT_CICLOS - 1);
   localparam logic [3:0] ULTIMA = 4'(N_JOGADAS - 1);

   // The encodings double as the codes shown on the hex debug display.
   typedef enum logic [3:0] {
      st_inicial        = 4'h0,
      st_preparacao     = 4'h1,
      st_espera_jogada  = 4'h2,
      st_registra       = 4'h3,
      st_comparacao     = 4'h4,
      st_proxima_jogada = 4'h5,
      st_proxima_rodada = 4'h6,
      st_fim_acerto     = 4'hA,
      st_fim_timeout    = 4'hD,
      st_fim_erro       = 4'hE
   } estado_t;

   estado_t       estado;
   estado_t       proximo;
   logic [CW-1:0] contador;

   // Next-state selection; a play arriving on the last allowed cycle beats the timeout.
   always_comb begin
      proximo = estado;
      case (estado)
         st_inicial:        if (iniciar) proximo = st_preparacao;
         st_preparacao:     proximo = st_espera_jogada;
         st_espera_jogada: begin
            if (tem_jogada)               proximo = st_registra;
            else if (contador == LIMITE)  proximo = st_fim_timeout;
         end
         st_registra:       proximo = st_comparacao;
         st_comparacao: begin
            if (!igual)                   proximo = st_fim_erro;
            else if (endereco < rodada)   proximo = st_proxima_jogada;
            else if (rodada < ULTIMA)     proximo = st_proxima_rodada;
            else                          proximo = st_fim_acerto;
         end
         st_proxima_jogada: proximo = st_espera_jogada;
         st_proxima_rodada: proximo = st_espera_jogada;
         st_fim_acerto, st_fim_timeout, st_fim_erro:
                            if (iniciar) proximo = st_preparacao;
         default:           proximo = st_inicial;
      endcase
   end

   // State register, registered Moore outputs and the address/round/timeout datapath.
   always_ff @(posedge clock) begin
      if (reset) begin
         estado    <= st_inicial;
         endereco  <= 4'd0;
         rodada    <= 4'd0;
         contador  <= '0;
         zera_reg  <= 1'b0;
         registra  <= 1'b0;
         acertou   <= 1'b0;
         errou     <= 1'b0;
         timeout   <= 1'b0;
         pronto    <= 1'b0;
         db_estado <= 4'h0;
      end else begin
         estado    <= proximo;
         db_estado <= proximo;
         zera_reg  <= (proximo == st_preparacao);
         registra  <= (proximo == st_registra);
         acertou   <= (proximo == st_fim_acerto);
         errou     <= (proximo == st_fim_erro);
         timeout   <= (proximo == st_fim_timeout);
         pronto    <= (proximo == st_fim_acerto) || (proximo == st_fim_erro) ||
                      (proximo == st_fim_timeout);
         case (estado)
            st_preparacao: begin
               endereco <= 4'd0;
               rodada   <= 4'd0;
               contador <= '0;
            end
            st_espera_jogada: begin
               if (tem_jogada || (contador == LIMITE)) contador <= '0;
               else                                    contador <= contador + CW'(1);
            end
            st_proxima_jogada: begin
               endereco <= endereco + 4'd1;
               contador <= '0;
            end
            st_proxima_rodada: begin
               rodada   <= rodada + 4'd1;
               endereco <= 4'd0;
               contador <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Bench for the round sequencer: a table of single-cycle vectors for start,
// two rounds and an error, then hand sequences for the full win, timeout,
// last-cycle play and mid-game reset.

module tb_unidade_controle_rodadas;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       iniciar = 1'b0;
   logic       tem_jogada = 1'b0;
   logic       igual = 1'b0;
   logic [3:0] endereco, rodada, db_estado;
   logic       zera_reg, registra, acertou, errou, timeout, pronto;

   int compared = 0;
   int mismatched = 0;
   int n_rodada = 0;
   int mod_end = 0;
   int mod_rod = 0;
   bit mod_won = 0;

   typedef struct {
      logic       rst;
      logic       ini;
      logic       tem;
      logic       ig;
      logic [3:0] st;
      logic [3:0] ende;
      logic [3:0] rod;
      logic       chk_addr;
   } vetor_t;

   vetor_t tabela[29];

   unidade_controle_rodadas #(.N_JOGADAS(16), .TIMEOUT_CICLOS(3000)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .tem_jogada(tem_jogada),
      .igual(igual), .endereco(endereco), .rodada(rodada), .zera_reg(zera_reg),
      .registra(registra), .acertou(acertou), .errou(errou), .timeout(timeout),
      .pronto(pronto), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   // One clock edge; outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_stimulus(input logic r, input logic i, input logic t, input logic g);
      reset = r;
      iniciar = i;
      tem_jogada = t;
      igual = g;
      step();
   endtask

   // Compares state code, flags decoded from the expected state, and optionally address/round.
   task automatic check_output(input string nome, input logic [3:0] st, input logic [3:0] ende,
                               input logic [3:0] rod, input logic chk_addr);
      logic [17:0] got, exp;
      logic        e_pronto;
      e_pronto = (st == 4'hA) || (st == 4'hD) || (st == 4'hE);
      got = {db_estado, zera_reg, registra, acertou, errou, timeout, pronto,
             chk_addr ? endereco : 4'd0, chk_addr ? rodada : 4'd0};
      exp = {st, st == 4'h1, st == 4'h3, st == 4'hA, st == 4'hE, st == 4'hD, e_pronto,
             chk_addr ? ende : 4'd0, chk_addr ? rod : 4'd0};
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got est=%h zr=%b rg=%b ac=%b er=%b to=%b pr=%b end=%0d rod=%0d, expected est=%h end=%0d rod=%0d (flags %b)",
                  nome, db_estado, zera_reg, registra, acertou, errou, timeout, pronto,
                  endereco, rodada, st, ende, rod, exp[9:4]);
      end
   endtask

   task automatic check_value(input string nome, input int got, input int exp);
      compared++;
      if (got != exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", nome, got, exp);
      end
   endtask

   // Reset, one cycle of iniciar, leaving the DUT in its first espera_jogada cycle.
   task automatic start_game();
      apply_stimulus(1, 0, 0, 0);
      apply_stimulus(0, 1, 0, 0);
      apply_stimulus(0, 0, 0, 0);
      mod_end = 0;
      mod_rod = 0;
      mod_won = 0;
   endtask

   // One correct play followed by 19 idle cycles, then compare with the round model.
   task automatic correct_play(input string nome);
      apply_stimulus(0, 0, 1, 1);
      tem_jogada = 1'b0;
      for (int k = 0; k < 19; k++) begin
         step();
         if (db_estado == 4'h6) n_rodada++;
      end
      if (mod_end < mod_rod) mod_end++;
      else if (mod_rod < 15) begin
         mod_rod++;
         mod_end = 0;
      end else mod_won = 1;
      check_output(nome, mod_won ? 4'hA : 4'h2, 4'(mod_end), 4'(mod_rod), 1);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      //               rst ini tem ig  st    end   rod  chk
      tabela[0]  = '{1, 0, 0, 0, 4'h0, 4'd0, 4'd0, 1};
      tabela[1]  = '{0, 1, 0, 0, 4'h1, 4'd0, 4'd0, 1};
      tabela[2]  = '{0, 1, 0, 0, 4'h2, 4'd0, 4'd0, 1};
      tabela[3]  = '{0, 1, 0, 0, 4'h2, 4'd0, 4'd0, 1};
      tabela[4]  = '{0, 1, 0, 0, 4'h2, 4'd0, 4'd0, 1};
      tabela[5]  = '{0, 1, 0, 0, 4'h2, 4'd0, 4'd0, 1};
      tabela[6]  = '{0, 0, 1, 0, 4'h3, 4'd0, 4'd0, 1};
      tabela[7]  = '{0, 0, 0, 1, 4'h4, 4'd0, 4'd0, 1};
      tabela[8]  = '{0, 0, 0, 1, 4'h6, 4'd0, 4'd0, 1};
      tabela[9]  = '{0, 0, 0, 1, 4'h2, 4'd0, 4'd1, 1};
      tabela[10] = '{0, 0, 1, 1, 4'h3, 4'd0, 4'd1, 1};
      tabela[11] = '{0, 0, 0, 1, 4'h4, 4'd0, 4'd1, 1};
      tabela[12] = '{0, 0, 0, 1, 4'h5, 4'd0, 4'd1, 1};
      tabela[13] = '{0, 0, 0, 1, 4'h2, 4'd1, 4'd1, 1};
      tabela[14] = '{0, 0, 1, 1, 4'h3, 4'd1, 4'd1, 1};
      tabela[15] = '{0, 0, 0, 1, 4'h4, 4'd1, 4'd1, 1};
      tabela[16] = '{0, 0, 0, 1, 4'h6, 4'd1, 4'd1, 1};
      tabela[17] = '{0, 0, 0, 1, 4'h2, 4'd0, 4'd2, 1};
      tabela[18] = '{0, 0, 1, 1, 4'h3, 4'd0, 4'd2, 1};
      tabela[19] = '{0, 0, 0, 1, 4'h4, 4'd0, 4'd2, 1};
      tabela[20] = '{0, 0, 0, 1, 4'h5, 4'd0, 4'd2, 1};
      tabela[21] = '{0, 0, 0, 1, 4'h2, 4'd1, 4'd2, 1};
      tabela[22] = '{0, 0, 1, 0, 4'h3, 4'd1, 4'd2, 1};
      tabela[23] = '{0, 0, 0, 0, 4'h4, 4'd1, 4'd2, 1};
      tabela[24] = '{0, 0, 0, 0, 4'hE, 4'd1, 4'd2, 1};
      tabela[25] = '{0, 0, 1, 0, 4'hE, 4'd1, 4'd2, 1};
      tabela[26] = '{0, 0, 1, 1, 4'hE, 4'd1, 4'd2, 1};
      tabela[27] = '{0, 1, 0, 0, 4'h1, 4'd0, 4'd0, 0};
      tabela[28] = '{0, 0, 0, 0, 4'h2, 4'd0, 4'd0, 1};

      for (int v = 0; v < 29; v++) begin
         apply_stimulus(tabela[v].rst, tabela[v].ini, tabela[v].tem, tabela[v].ig);
         check_output($sformatf("vector %0d", v), tabela[v].st, tabela[v].ende,
                      tabela[v].rod, tabela[v].chk_addr);
      end

      // Full win: 136 correct plays.
      start_game();
      n_rodada = 0;
      for (int p = 0; p < 136; p++) correct_play($sformatf("win play %0d", p));
      check_value("win proxima_rodada visits", n_rodada, 15);
      check_output("win final", 4'hA, 4'd15, 4'd15, 1);

      // Timeout: count cycles spent in espera_jogada.
      start_game();
      n = 1;
      for (int i = 0; i < 4000; i++) begin
         step();
         if (db_estado == 4'h2) n++;
         else break;
      end
      check_value("timeout wait cycles", n, 3000);
      check_output("timeout final", 4'hD, 4'd0, 4'd0, 1);

      // A play on the 3000th waiting cycle wins over the timeout.
      start_game();
      repeat (2999) step();
      check_output("last cycle still waiting", 4'h2, 4'd0, 4'd0, 1);
      apply_stimulus(0, 0, 1, 0);
      check_output("last cycle play", 4'h3, 4'd0, 4'd0, 1);
      tem_jogada = 1'b0;

      // Reset in the middle of round 5, then a play in inicial is ignored.
      start_game();
      for (int p = 0; p < 15; p++) correct_play($sformatf("pre-reset play %0d", p));
      check_output("reached round 5", 4'h2, 4'd0, 4'd5, 1);
      apply_stimulus(1, 0, 0, 0);
      check_output("mid-game reset", 4'h0, 4'd0, 4'd0, 1);
      apply_stimulus(0, 0, 1, 0);
      check_output("play in inicial", 4'h0, 4'd0, 4'd0, 1);
      apply_stimulus(0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/unidade_controle_rodadas.md
Name: unidade_controle_rodadas

Overview:
Control unit for the sequence-memory game datapath: memory of 16 stored plays, jogada register, comparator and edge-detected play input. It sequences rounds: round k requires the player to repeat plays 0..k in order. Each wait for a play is guarded by a timeout. It drives memory address, register load/clear and the game result outputs, and exposes its state code for the hex debug display.

Parameters:
N_JOGADAS, 16, number of rounds and stored plays (max 16, fits 4-bit address)
TIMEOUT_CICLOS, 3000, clock cycles allowed per play wait (3 s at 1 kHz)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
iniciar  in  1  start/restart request (level)
tem_jogada  in  1  one-cycle pulse from edge detector when chaves becomes nonzero
igual  in  1  comparator result: jogada register == memory[endereco]
endereco  out  4  memory address of the expected play
rodada  out  4  current round index (last address of this round)
zera_reg  out  1  clear jogada register
registra  out  1  load jogada register from chaves
acertou  out  1  game won
errou  out  1  wrong play
timeout  out  1  play not made in time
pronto  out  1  game finished (any outcome)
db_estado  out  4  state code for debug display

Behaviour:
- Synchronous reset: on any rising edge with reset=1 -> inicial; endereco=0, rodada=0, timeout counter=0. All control/result outputs are 0 and db_estado=0. This holds from any state, including mid-game.
- State codes are shown on db_estado: inicial 0, preparacao 1, espera_jogada 2, registra 3, comparacao 4, proxima_jogada 5, proxima_rodada 6, fim_acerto A, fim_timeout D, fim_erro E.
- Moore outputs decode from the state only. endereco, rodada and the counter are registered.
- inicial: iniciar=1 -> preparacao; otherwise stay. tem_jogada is ignored.
- preparacao (1 cycle):
  - zera_reg=1; endereco<=0; rodada<=0; counter<=0.
  - -> espera_jogada.
- espera_jogada:
  - counter increments each cycle.
  - tem_jogada=1 -> registra, counter<=0.
  - Else, if counter==TIMEOUT_CICLOS-1 -> fim_timeout. The state is therefore occupied for exactly TIMEOUT_CICLOS cycles before timing out.
  - tem_jogada on that final cycle wins over timeout.
- registra (1 cycle): registra=1 -> comparacao. igual is evaluated in the following cycle.
- comparacao:
  - igual=0 -> fim_erro.
  - igual=1 and endereco<rodada -> proxima_jogada.
  - igual=1 and endereco==rodada and rodada<N_JOGADAS-1 -> proxima_rodada.
  - igual=1 and endereco==rodada==N_JOGADAS-1 -> fim_acerto.
- proxima_jogada: endereco<=endereco+1; counter<=0; -> espera_jogada.
- proxima_rodada: rodada<=rodada+1; endereco<=0; counter<=0; -> espera_jogada.
- Terminal states:
  - pronto=1 plus acertou (fim_acerto), errou (fim_erro) or timeout (fim_timeout).
  - Outputs are held, and endereco/rodada are frozen at their failing/final values.
  - iniciar=1 -> preparacao (restart); tem_jogada is ignored.
- iniciar is ignored in all non-inicial, non-terminal states.
- Counter width is ceil(log2(TIMEOUT_CICLOS)) and it never wraps (cleared before reaching TIMEOUT_CICLOS).
- endereco never exceeds rodada; rodada never exceeds N_JOGADAS-1.
- Total plays for a full win: N_JOGADAS*(N_JOGADAS+1)/2 (136 at default).

Test Plan:
- Reset pulse, then iniciar=1 for 5 cycles -> db_estado 0 -> 1 (exactly one cycle, zera_reg=1) -> 2; endereco=0, rodada=0; no further preparacao despite iniciar held.
- igual tied 1, 136 tem_jogada pulses spaced 20 cycles -> rodada steps 0..15, db_estado passes 6 fifteen times, ends at A with acertou=1, pronto=1, errou=0, timeout=0, rodada=15, endereco=15.
- Rounds 0 and 1 correct, then in round 2 igual=0 on the second play -> db_estado E, errou=1, pronto=1, rodada=2, endereco=1; further tem_jogada pulses leave the state unchanged.
- No play after preparacao -> exactly 3000 cycles in state 2, then D with timeout=1, pronto=1. Repeat with tem_jogada on the 3000th cycle -> state 3, no timeout.
- From fim_erro assert iniciar -> state 1 then 2; errou, pronto cleared; endereco=0, rodada=0.
- reset=1 for one edge while rodada=5 in espera_jogada -> next state 0, all outputs 0. Then tem_jogada in inicial -> stays 0.
